// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
//  Shared definitions for the MEM-stage load/store unit: FSM state encoding,
//  access-size codes, pipeline control levels and small helper functions for
//  alignment checking and byte-strobe generation.
package mem_stage_lsu_pkg;

    localparam int LSU_XLEN = 64;

    // Level driven on mem_stall_req to hold the pipeline, and the reset-active level
    localparam logic YSYX22040228_STOP   = 1'b1;
    localparam logic YSYX22040228_RSTENA = 1'b1;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // An access is aligned when the low address bits below its size are zero
    function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = (addr_lo[0] == 1'b0);
            SIZE_W:  ok = (addr_lo[1:0] == 2'b00);
            SIZE_D:  ok = (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane mask for an access of the given size, starting at lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            SIZE_D:  m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_ext.sv
// mem_load_ext
//  Combinational load-data alignment: shifts the returned doubleword down to the
//  accessed byte lane and sign- or zero-extends it to XLEN.
//  Ports:
//    rdata   in  XLEN  doubleword from the cache
//    addr    in  3     byte offset within the doubleword
//    size    in  2     access size code (B/H/W/D)
//    uns     in  1     zero-extend instead of sign-extend
//    data    out XLEN  aligned, extended load value
module mem_load_ext
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted_s;

    assign shifted_s = rdata >> {addr, 3'b000};

    // Select the extension width from the access size
    always_comb begin
        data = shifted_s;
        case (size)
            SIZE_B:  data = uns ? {{(XLEN-8){1'b0}},  shifted_s[7:0]}
                                : {{(XLEN-8){shifted_s[7]}},   shifted_s[7:0]};
            SIZE_H:  data = uns ? {{(XLEN-16){1'b0}}, shifted_s[15:0]}
                                : {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            SIZE_W:  data = uns ? {{(XLEN-32){1'b0}}, shifted_s[31:0]}
                                : {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
            SIZE_D:  data = shifted_s;
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//  MEM-stage load/store unit. Runs one request/response transaction on the
//  data-cache port for the access held in EX/MEM, stalls the pipeline while it is
//  in flight and delivers aligned, extended load data to MEM/WB.
//  Ports:
//    clk, rst                 clock, asynchronous active-high reset
//    op_valid/op_store/op_size/op_unsigned/op_addr/op_wdata   access from EX/MEM
//    flush                    kill the current access
//    req_valid/req_ready/req_wen/req_addr/req_wdata/req_wstrb cache request channel
//    resp_valid/resp_err/resp_rdata                          cache response channel
//    mem_stall_req            hold the pipeline
//    wb_valid/wb_rdata        one-cycle result to MEM/WB
//    exc_misalign/exc_access  exception flags
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic            op_store,
    input  logic [1:0]      op_size,
    input  logic            op_unsigned,
    input  logic [XLEN-1:0] op_addr,
    input  logic [XLEN-1:0] op_wdata,
    input  logic            flush,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_wen,
    output logic [XLEN-1:0] req_addr,
    output logic [XLEN-1:0] req_wdata,
    output logic [7:0]      req_wstrb,
    input  logic            resp_valid,
    input  logic            resp_err,
    input  logic [XLEN-1:0] resp_rdata,
    output logic            mem_stall_req,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_rdata,
    output logic            exc_misalign,
    output logic            exc_access
);

    lsu_state_t      state_r;
    lsu_state_t      state_s;

    logic            aligned_s;
    logic            stall_s;
    logic            misalign_s;
    logic            req_valid_s;
    logic            wb_valid_s;
    logic            exc_access_s;

    logic            start_s;
    logic            killed_r;
    logic            err_r;
    logic            store_r;
    logic [1:0]      size_r;
    logic            uns_r;
    logic [2:0]      off_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [7:0]      wstrb_r;
    logic [XLEN-1:0] data_r;
    logic [XLEN-1:0] ext_s;

    assign aligned_s = is_aligned(op_addr[2:0], op_size);
    assign start_s   = (state_r == LSU_IDLE) && (state_s == LSU_REQ);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == YSYX22040228_RSTENA) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_s      = state_r;
        stall_s      = ~YSYX22040228_STOP;
        misalign_s   = 1'b0;
        req_valid_s  = 1'b0;
        wb_valid_s   = 1'b0;
        exc_access_s = 1'b0;
        case (state_r)
            LSU_IDLE: begin
                if (op_valid && !aligned_s) begin
                    misalign_s = 1'b1;
                    state_s    = LSU_IDLE;
                end else if (op_valid && !flush) begin
                    stall_s = YSYX22040228_STOP;
                    state_s = LSU_REQ;
                end else begin
                    state_s = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                stall_s     = YSYX22040228_STOP;
                req_valid_s = 1'b1;
                if (req_ready) begin
                    state_s = LSU_RESP;
                end else begin
                    state_s = LSU_REQ;
                end
            end
            LSU_RESP: begin
                stall_s = YSYX22040228_STOP;
                if (resp_valid) begin
                    state_s = LSU_DONE;
                end else begin
                    state_s = LSU_RESP;
                end
            end
            LSU_DONE: begin
                // Always return to IDLE so the op still held in EX/MEM is not reissued
                wb_valid_s   = ~killed_r & ~flush;
                exc_access_s = err_r & ~killed_r & ~flush;
                state_s      = LSU_IDLE;
            end
            default: begin
                state_s = LSU_IDLE;
            end
        endcase
    end

    // Request fields are frozen at IDLE->REQ and held until the next access
    always_ff @(posedge clk or posedge rst) begin
        if (rst == YSYX22040228_RSTENA) begin
            addr_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= 8'h00;
            store_r <= 1'b0;
            size_r  <= SIZE_B;
            uns_r   <= 1'b0;
            off_r   <= 3'b000;
        end else if (start_s) begin
            addr_r  <= {op_addr[XLEN-1:3], 3'b000};
            wdata_r <= op_wdata << {op_addr[2:0], 3'b000};
            wstrb_r <= op_store ? 8'(size_mask(op_size) << op_addr[2:0]) : 8'h00;
            store_r <= op_store;
            size_r  <= op_size;
            uns_r   <= op_unsigned;
            off_r   <= op_addr[2:0];
        end
    end

    // Sticky kill: a flush while the bus is busy discards the eventual result
    always_ff @(posedge clk or posedge rst) begin
        if (rst == YSYX22040228_RSTENA) begin
            killed_r <= 1'b0;
        end else if (state_s == LSU_IDLE) begin
            killed_r <= 1'b0;
        end else if (((state_r == LSU_REQ) || (state_r == LSU_RESP)) && flush) begin
            killed_r <= 1'b1;
        end
    end

    // Capture extended load data and bus error when the response arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst == YSYX22040228_RSTENA) begin
            data_r <= '0;
            err_r  <= 1'b0;
        end else if ((state_r == LSU_RESP) && resp_valid) begin
            data_r <= store_r ? '0 : ext_s;
            err_r  <= resp_err;
        end
    end

    mem_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata (resp_rdata),
        .addr  (off_r),
        .size  (size_r),
        .uns   (uns_r),
        .data  (ext_s)
    );

    // Combinational outputs are forced low while reset is held
    assign mem_stall_req = stall_s & ~rst;
    assign exc_misalign  = misalign_s & ~rst;
    assign req_valid     = req_valid_s & ~rst;
    assign wb_valid      = wb_valid_s & ~rst;
    assign exc_access    = exc_access_s & ~rst;
    assign wb_rdata      = wb_valid ? data_r : '0;
    assign req_wen       = store_r;
    assign req_addr      = addr_r;
    assign req_wdata     = wdata_r;
    assign req_wstrb     = wstrb_r;

endmodule
